// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: front-end stage for the subtractive GCD core.
// Turns operand-pair jobs into core start/load/clear cycles, returns results.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     operand stream handshake; in_a, in_b operands
//   core_start            one-cycle start pulse to the core
//   core_data             shared operand bus (A in START/LOAD_A, B in LOAD_B)
//   core_clr              returns the core to idle (also held during reset)
//   core_done/core_result core completion and its register-A value
//   out_valid/out_ready   result stream handshake; out_gcd, out_err result
//   busy                  high whenever a job is in flight
module gcd_job_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 65600,
  parameter int TO_W    = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data,
  output logic             core_clr,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             busy
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_CLEAR,
    S_OUT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_gcd;
  logic             r_err;
  logic [TO_W-1:0]  r_wd;

  logic             w_accept;
  logic             w_zero;
  logic [WIDTH-1:0] w_core_data;

  assign w_accept = in_valid & in_ready;
  assign w_zero   = (in_a == '0) | (in_b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_gcd   <= '0;
      r_err   <= 1'b0;
      r_wd    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a <= in_a;
            r_b <= in_b;
            // The core never terminates on a zero operand; gcd(x,0)=x.
            if (w_zero) begin
              r_gcd   <= in_a | in_b;
              r_err   <= 1'b0;
              r_state <= S_OUT;
            end else begin
              r_state <= S_START;
            end
          end
        end
        S_START:  r_state <= S_LOAD_A;
        S_LOAD_A: r_state <= S_LOAD_B;
        S_LOAD_B: begin
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // done wins over a timeout landing in the same cycle
          if (core_done) begin
            r_gcd   <= core_result;
            r_err   <= 1'b0;
            r_state <= S_CLEAR;
          end else if (r_wd == TO_LAST) begin
            r_gcd   <= '0;
            r_err   <= 1'b1;
            r_state <= S_CLEAR;
          end else begin
            r_wd <= r_wd + TO_W'(1);
          end
        end
        S_CLEAR: r_state <= S_OUT;
        S_OUT: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_core_data = '0;
    case (r_state)
      S_START:  w_core_data = r_a;
      S_LOAD_A: w_core_data = r_a;
      S_LOAD_B: w_core_data = r_b;
      default:  w_core_data = '0;
    endcase
  end

  // rst_n gating keeps in_ready low while reset is held in IDLE.
  assign in_ready   = rst_n & (r_state == S_IDLE);
  assign core_start = (r_state == S_START);
  assign core_data  = w_core_data;
  assign core_clr   = ~rst_n | (r_state == S_CLEAR);
  assign out_valid  = (r_state == S_OUT);
  assign out_gcd    = r_gcd;
  assign out_err    = r_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/gcd_job_sequencer.md
Name: gcd_job_sequencer

Overview:
- Front-end stage directly upstream of the subtractive GCD core (controller plus datapath).
- Accepts operand pairs from a valid/ready stream and sequences them into the core's start and shared data-input protocol.
- Captures the core's result on done, clears the core for the next job, and presents the result on a valid/ready output stream.
- Handles zero operands, which the core cannot terminate on, and bounds runtime with a watchdog.

Parameters:
- WIDTH, 16, operand and result width.
- TIMEOUT, 65600, maximum WAIT cycles before a job is aborted; must be ≥ 2.
- TO_W, 17, watchdog counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- core_start  out  1  start pulse to the GCD core.
- core_data  out  WIDTH  shared operand bus to the core's input mux.
- core_clr  out  1  returns the core from its done state to idle.
- core_done  in  1  core finished; result valid.
- core_result  in  WIDTH  core register-A value.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_gcd  out  WIDTH  GCD result.
- out_err  out  1  result aborted by watchdog.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, START, LOAD_A, LOAD_B, WAIT, CLEAR, OUT.
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - Held operands, out_gcd, out_err and the watchdog counter clear to 0.
  - in_ready, out_valid, core_start and busy are 0.
  - core_clr = ~rst_n | (state==CLEAR), so the core is flushed while reset is held, including mid-job.
- IDLE:
  - in_ready=1.
  - A handshake latches a and b.
  - If a==0 or b==0: out_gcd <= a|b (gives gcd(x,0)=x and gcd(0,0)=0), out_err <= 0, go to OUT. The core is never started.
  - Otherwise go to START.
- START: core_start=1, core_data=a.
- LOAD_A: core_data=a; the core loads A this cycle.
- LOAD_B: core_data=b; the core loads B. Watchdog clears to 0.
- core_data is 0 in all other states.
- WAIT:
  - If core_done=1: out_gcd <= core_result, out_err <= 0, go to CLEAR.
  - Otherwise increment the watchdog. If it equals TIMEOUT-1: out_gcd <= 0, out_err <= 1, go to CLEAR.
  - core_done takes priority over a simultaneous timeout.
- CLEAR: core_clr=1 for exactly one cycle, then OUT.
- OUT:
  - out_valid=1; out_gcd and out_err are held stable.
  - On out_ready go to IDLE. in_ready=0 until then.
- Latency (accept edge at cycle k):
  - core_start is high in cycle k+1.
  - The core loads A at k+2 and B at k+3; WAIT begins at k+4.
  - out_valid rises 2 cycles after core_done is sampled high.
  - Zero bypass: out_valid rises in cycle k+1.
- core_done seen outside WAIT is ignored.
- in_ready and out_valid are never both 1. The block processes one job at a time, with no overlap.
- The watchdog saturates logically: it never wraps, because WAIT is exited at TIMEOUT-1.

Test Plan:
- Basic job: a=48, b=18 with a behavioural core model.
  - core_start in k+1; core_data=48 in k+1..k+2 and 18 in k+3.
  - out_gcd=6, out_err=0, core_clr pulses once.
- Zero bypass: (0,35) gives 35, (35,0) gives 35, (0,0) gives 0.
  - core_start never asserts; out_valid at k+1.
- Watchdog: TIMEOUT=16, core model never asserts done.
  - After 16 WAIT cycles: out_err=1, out_gcd=0, one core_clr pulse.
- Simultaneous: core_done asserted in the timeout cycle gives out_err=0 and out_gcd=core_result.
- Backpressure: (21,14) result held with out_ready=0 for 5 cycles.
  - out_gcd stays 7, in_ready stays 0, in_valid is ignored.
  - Then (9,6) is accepted and gives 3.
- Reset mid-WAIT: rst_n low for 2 cycles.
  - core_clr=1 during reset; all outputs are 0 and state is IDLE.
  - A subsequent (100,75) gives 25.
